// File: rtl/hack_test_rom.sv
// Synchronous-read instruction ROM for Hack bring-up; holds a fixed 8-word test
// program and drives the CPU instruction bus through a single output register.
module hack_test_rom #(
  parameter int unsigned DEPTH      = 32768,
  parameter int unsigned INIT_WORDS = 8
) (
  input  logic        clka,
  input  logic        reset,
  input  logic        ena,
  input  logic [31:0] addra,
  output logic [15:0] douta
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned PROG_W = 3;

  logic [DATA_W-1:0] douta_q;
  logic [DATA_W-1:0] douta_d;
  logic [DATA_W-1:0] rom_word_c;
  logic              in_prog_c;

  // Only the leading program words carry content; everything else, including
  // addresses past DEPTH or with upper bits set, decodes to zero.
  assign in_prog_c = (addra < ADDR_W'(DEPTH)) && (addra < ADDR_W'(INIT_WORDS));

  always_comb begin
    rom_word_c = '0;
    if (in_prog_c) begin
      unique case (addra[PROG_W-1:0])
        3'd0:    rom_word_c = 16'h0000; // @0
        3'd1:    rom_word_c = 16'hEC10; // D=A
        3'd2:    rom_word_c = 16'h0002; // @2
        3'd3:    rom_word_c = 16'hE090; // D=D+A
        3'd4:    rom_word_c = 16'h0003; // @3
        3'd5:    rom_word_c = 16'hE308; // M=D
        3'd6:    rom_word_c = 16'h0006; // @6
        3'd7:    rom_word_c = 16'hEA87; // 0;JMP
        default: rom_word_c = '0;
      endcase
    end
  end

  always_comb begin
    douta_d = douta_q;
    if (ena) begin
      douta_d = rom_word_c;
    end
  end

  always_ff @(posedge clka or negedge reset) begin
    if (!reset) begin
      douta_q <= '0;
    end else begin
      douta_q <= douta_d;
    end
  end

  assign douta = douta_q;

endmodule

// File: tb/tb_hack_test_rom.sv
// Directed bench for hack_test_rom: reset, program fetch, enable hold, bounds,
// asynchronous reset and read latency against hand-computed instruction words.
module tb_hack_test_rom;

  logic        clka;
  logic        reset;
  logic        ena;
  logic [31:0] addra;
  logic [15:0] douta;

  int unsigned n_vec;
  int unsigned n_err;

  hack_test_rom dut (
    .clka  (clka),
    .reset (reset),
    .ena   (ena),
    .addra (addra),
    .douta (douta)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  task automatic check16(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: douta=0x%04h expected 0x%04h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic read_at(input logic [31:0] a);
    addra = a;
    tick();
  endtask

  logic [15:0] prog [8];

  initial begin
    prog[0] = 16'h0000; prog[1] = 16'hEC10; prog[2] = 16'h0002; prog[3] = 16'hE090;
    prog[4] = 16'h0003; prog[5] = 16'hE308; prog[6] = 16'h0006; prog[7] = 16'hEA87;
    n_vec = 0;
    n_err = 0;

    // Reset held low: output cleared without and across clock edges.
    reset = 1'b1;
    ena   = 1'b1;
    addra = 32'd3;
    #2 reset = 1'b0;
    #1 check16("reset_async", douta, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check16("reset_hold", douta, 16'h0000);
    end
    reset = 1'b1;
    tick();
    check16("reset_release", douta, 16'hE090);

    // Sequential fetch of the whole program.
    for (int i = 0; i < 8; i++) begin
      read_at(32'(i));
      check16($sformatf("fetch_%0d", i), douta, prog[i]);
    end

    // Enable low holds the previous word regardless of address.
    read_at(32'd5);
    check16("hold_load", douta, 16'hE308);
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      read_at(32'd7);
      check16("hold_ena0", douta, 16'hE308);
    end
    ena = 1'b1;
    tick();
    check16("hold_resume", douta, 16'hEA87);

    // Blank region and out-of-range addresses, each after a non-zero read.
    begin
      logic [31:0] bnd [4];
      bnd[0] = 32'd8; bnd[1] = 32'd32767; bnd[2] = 32'd32768; bnd[3] = 32'h0001_0000;
      for (int i = 0; i < 4; i++) begin
        read_at(32'd1);
        check16("bound_pre", douta, 16'hEC10);
        read_at(bnd[i]);
        check16($sformatf("bound_0x%08h", bnd[i]), douta, 16'h0000);
      end
    end
    // Upper bits set must not alias onto program words.
    read_at(32'h0001_0001);
    check16("alias_hi", douta, 16'h0000);

    // Asynchronous reset between clock edges.
    read_at(32'd7);
    check16("mid_pre", douta, 16'hEA87);
    #2 reset = 1'b0;
    #1 check16("mid_async", douta, 16'h0000);
    @(negedge clka);
    reset = 1'b1;

    // One-cycle latency: a late address change waits for the next edge.
    read_at(32'd1);
    check16("lat_first", douta, 16'hEC10);
    #1 addra = 32'd3;
    #2 check16("lat_hold", douta, 16'hEC10);
    tick();
    check16("lat_next", douta, 16'hE090);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
